// File: rtl/multicycle_sequencer_pkg.sv
// Shared encodings and sizing helpers for the multi-cycle instruction sequencer.
package seq_pkg;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        DEC   = 3'd1,
        MEM   = 3'd2,
        WB    = 3'd3,
        HALT  = 3'd4,
        ERR   = 3'd5
    } state_e;

    localparam int DEF_MEM_TIMEOUT = 64;
    localparam int DEF_CNT_W       = 16;

    // A zero timeout still needs a one-bit counter so the datapath stays legal.
    function automatic int wait_w(input int tmo);
        return (tmo < 1) ? 1 : $clog2(tmo + 1);
    endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Decoder, memory-handshake and control-strobe bundle of the sequencer.
// SEQ_PERF_CNT_EN adds the perf_retired/perf_stall counter outputs.
interface multicycle_sequencer_if #(parameter int CNT_W = 16);

    logic       dec_halt, dec_mem_rd, dec_mem_wr, dec_wr_reg, dec_err;
    logic       imem_done, imem_stall, dmem_done, dmem_stall;
    logic       imem_rd, dmem_rd, dmem_wr, ir_load, pc_we, reg_we, retire;
    logic       halted, err;
    logic [2:0] state_o;
`ifdef SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] perf_retired, perf_stall;
`else
    localparam int cnt_w_unused = CNT_W;
`endif

    modport master (
        input  dec_halt, dec_mem_rd, dec_mem_wr, dec_wr_reg, dec_err,
        input  imem_done, imem_stall, dmem_done, dmem_stall,
`ifdef SEQ_PERF_CNT_EN
        output perf_retired, perf_stall,
`endif
        output imem_rd, dmem_rd, dmem_wr, ir_load, pc_we, reg_we, retire,
        output halted, err, state_o
    );

    modport slave (
        output dec_halt, dec_mem_rd, dec_mem_wr, dec_wr_reg, dec_err,
        output imem_done, imem_stall, dmem_done, dmem_stall,
`ifdef SEQ_PERF_CNT_EN
        input  perf_retired, perf_stall,
`endif
        input  imem_rd, dmem_rd, dmem_wr, ir_load, pc_we, reg_we, retire,
        input  halted, err, state_o
    );

endinterface

// File: rtl/multicycle_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/multicycle_sequencer.sv
// FETCH/DEC/MEM/WB sequencer over stallable memories with a request timeout.
// SEQ_PERF_CNT_EN adds saturating retired/stall performance counters.
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_sequencer_if.master bus
);

    localparam int WAIT_W = wait_w(MEM_TIMEOUT);

    state_e            state_q, state_d;
    logic              fetch_q, mem_q, wb_q, halt_q, err_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              got_done, stall_cyc, tmo_hit, wait_clr;
    logic              mem_busy_unused;

    // Busy flags are informational only: a request is held until done regardless.
    assign mem_busy_unused = bus.imem_stall | bus.dmem_stall;

    assign got_done  = (fetch_q & bus.imem_done) | (mem_q & bus.dmem_done);
    assign stall_cyc = (fetch_q | mem_q) & ~got_done;
    assign tmo_hit   = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_W'(MEM_TIMEOUT));
    assign wait_clr  = (state_d != state_q) && ((state_d == FETCH) || (state_d == MEM));

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: if (got_done) state_d = DEC;
                   else if (stall_cyc && tmo_hit) state_d = ERR;
            DEC: begin
                if (bus.dec_err)                         state_d = ERR;
                else if (bus.dec_halt)                   state_d = HALT;
                else if (bus.dec_mem_rd && bus.dec_mem_wr) state_d = ERR;
                else if (bus.dec_mem_rd || bus.dec_mem_wr) state_d = MEM;
                else                                     state_d = WB;
            end
            MEM:   if (got_done) state_d = WB;
                   else if (tmo_hit) state_d = ERR;
            WB:    state_d = FETCH;
            HALT:  state_d = HALT;
            ERR:   state_d = ERR;
            default: state_d = ERR;
        endcase
    end

    // Strobe flags lag reset release by one edge, so the release cycle issues nothing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            fetch_q <= 1'b0;
            mem_q   <= 1'b0;
            wb_q    <= 1'b0;
            halt_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fetch_q <= (state_d == FETCH);
            mem_q   <= (state_d == MEM);
            wb_q    <= (state_d == WB);
            halt_q  <= (state_d == HALT);
            err_q   <= (state_d == ERR);
        end
    end

    sat_counter #(.W(WAIT_W)) u_wait (
        .clk(clk), .rst(rst), .inc_i(stall_cyc), .clr_i(wait_clr), .cnt_o(wait_cnt)
    );

    assign bus.imem_rd = fetch_q;
    assign bus.ir_load = fetch_q & bus.imem_done;
    assign bus.dmem_rd = mem_q & bus.dec_mem_rd;
    assign bus.dmem_wr = mem_q & bus.dec_mem_wr;
    assign bus.pc_we   = wb_q;
    assign bus.retire  = wb_q;
    assign bus.reg_we  = wb_q & bus.dec_wr_reg;
    assign bus.halted  = halt_q;
    assign bus.err     = err_q;
    assign bus.state_o = state_q;

`ifdef SEQ_PERF_CNT_EN
    sat_counter #(.W(CNT_W)) u_perf_ret (
        .clk(clk), .rst(rst), .inc_i(wb_q), .clr_i(1'b0), .cnt_o(bus.perf_retired)
    );
    sat_counter #(.W(CNT_W)) u_perf_stall (
        .clk(clk), .rst(rst), .inc_i(stall_cyc), .clr_i(1'b0), .cnt_o(bus.perf_stall)
    );
`else
    localparam int cnt_w_unused = CNT_W;
`endif

endmodule
